// File: rtl/ldm_stm_sequencer.sv
// Block-transfer (LDM/STM) sequencer: walks a 16-bit register list lowest-first,
// issuing one memory access per listed register plus optional base writeback.
module ldm_stm_sequencer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RESETn,
    input  logic              Start,
    input  logic              IsLoad,
    input  logic [15:0]       RegList,
    input  logic [3:0]        Rn,
    input  logic [ADDR_W-1:0] BaseVal,
    input  logic              Up,
    input  logic              Pre,
    input  logic              WBack,
    input  logic              MemReady,
    input  logic [DATA_W-1:0] ReadData,
    input  logic [DATA_W-1:0] RD1,
    output logic [3:0]        RFA1,
    output logic [3:0]        RFA3,
    output logic              WE3,
    output logic [DATA_W-1:0] WD3,
    output logic              MemReq,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWData,
    output logic              PCWrite,
    output logic              Busy,
    output logic              Done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_XFER,
        S_WB,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       pending_q, pending_d;
    logic [3:0]        rn_q, rn_d;
    logic              is_load_q, is_load_d;
    logic              wback_q, wback_d;
    logic              rn_in_list_q, rn_in_list_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] final_q, final_d;

    logic [4:0]        reg_count;
    logic [ADDR_W-1:0] four_n;
    logic [3:0]        cur;
    logic [15:0]       cur_mask;

    always_comb begin
        reg_count = 5'd0;
        for (int i = 0; i < 16; i++) begin
            reg_count = reg_count + 5'(RegList[i]);
        end
    end

    assign four_n = ADDR_W'(reg_count) << 2;

    // Scan downward so the last hit is the lowest set bit.
    always_comb begin
        cur = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (pending_q[i]) begin
                cur = 4'(i);
            end
        end
    end

    assign cur_mask = 16'd1 << cur;

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        rn_d         = rn_q;
        is_load_d    = is_load_q;
        wback_d      = wback_q;
        rn_in_list_d = rn_in_list_q;
        addr_d       = addr_q;
        final_d      = final_q;

        RFA1     = 4'd0;
        RFA3     = 4'd0;
        WE3      = 1'b0;
        WD3      = '0;
        MemReq   = 1'b0;
        MemWrite = 1'b0;
        MemAddr  = '0;
        MemWData = '0;
        PCWrite  = 1'b0;
        Done     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    pending_d    = RegList;
                    rn_d         = Rn;
                    is_load_d    = IsLoad;
                    wback_d      = WBack;
                    rn_in_list_d = RegList[Rn];
                    if (Up) begin
                        addr_d  = Pre ? BaseVal + ADDR_W'(4) : BaseVal;
                        final_d = BaseVal + four_n;
                    end else begin
                        addr_d  = Pre ? BaseVal - four_n : BaseVal - four_n + ADDR_W'(4);
                        final_d = BaseVal - four_n;
                    end
                    state_d = (RegList == 16'd0) ? S_DONE : S_XFER;
                end
            end
            S_XFER: begin
                MemReq  = 1'b1;
                MemAddr = addr_q;
                if (!is_load_q) begin
                    MemWrite = 1'b1;
                    RFA1     = cur;
                    MemWData = RD1;
                end
                if (MemReady) begin
                    pending_d = pending_q & ~cur_mask;
                    addr_d    = addr_q + ADDR_W'(4);
                    if (is_load_q) begin
                        WD3 = ReadData;
                        if (cur == 4'd15) begin
                            PCWrite = 1'b1;
                        end else begin
                            WE3  = 1'b1;
                            RFA3 = cur;
                        end
                    end
                    if (pending_d == 16'd0) begin
                        // A loaded base register keeps the loaded value.
                        state_d = (wback_q && !(is_load_q && rn_in_list_q)) ? S_WB : S_DONE;
                    end
                end
            end
            S_WB: begin
                WE3     = 1'b1;
                RFA3    = rn_q;
                WD3     = DATA_W'(final_q);
                state_d = S_DONE;
            end
            S_DONE: begin
                Done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign Busy = (state_q != S_IDLE);

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state_q      <= S_IDLE;
            pending_q    <= 16'd0;
            rn_q         <= 4'd0;
            is_load_q    <= 1'b0;
            wback_q      <= 1'b0;
            rn_in_list_q <= 1'b0;
            addr_q       <= '0;
            final_q      <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            rn_q         <= rn_d;
            is_load_q    <= is_load_d;
            wback_q      <= wback_d;
            rn_in_list_q <= rn_in_list_d;
            addr_q       <= addr_d;
            final_q      <= final_d;
        end
    end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Directed bench for ldm_stm_sequencer: STM/LDM addressing modes, stalls,
// empty list, mid-transfer reset, ignored Start and address wrap.
module tb_ldm_stm_sequencer;

    logic        CLK = 1'b0;
    logic        RESETn;
    logic        Start;
    logic        IsLoad;
    logic [15:0] RegList;
    logic [3:0]  Rn;
    logic [31:0] BaseVal;
    logic        Up;
    logic        Pre;
    logic        WBack;
    logic        MemReady;
    logic [31:0] ReadData;
    logic [31:0] RD1;
    logic [3:0]  RFA1;
    logic [3:0]  RFA3;
    logic        WE3;
    logic [31:0] WD3;
    logic        MemReq;
    logic        MemWrite;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic        PCWrite;
    logic        Busy;
    logic        Done;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    // Register file stand-in: Ri reads as 0xD000000i.
    assign RD1 = {28'hD000000, RFA1};

    ldm_stm_sequencer #(.ADDR_W(32), .DATA_W(32)) dut (
        .CLK(CLK), .RESETn(RESETn), .Start(Start), .IsLoad(IsLoad),
        .RegList(RegList), .Rn(Rn), .BaseVal(BaseVal), .Up(Up), .Pre(Pre),
        .WBack(WBack), .MemReady(MemReady), .ReadData(ReadData), .RD1(RD1),
        .RFA1(RFA1), .RFA3(RFA3), .WE3(WE3), .WD3(WD3), .MemReq(MemReq),
        .MemWrite(MemWrite), .MemAddr(MemAddr), .MemWData(MemWData),
        .PCWrite(PCWrite), .Busy(Busy), .Done(Done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then settle just past the edge before driving/sampling.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk_mem(input string tag, input logic req, input logic wr, input logic [31:0] addr);
        chk({tag, ".MemReq"}, 32'(MemReq), 32'(req));
        chk({tag, ".MemWrite"}, 32'(MemWrite), 32'(wr));
        chk({tag, ".MemAddr"}, MemAddr, addr);
    endtask

    task automatic chk_rf(input string tag, input logic we, input logic [3:0] a3, input logic [31:0] wd, input logic pcw);
        chk({tag, ".WE3"}, 32'(WE3), 32'(we));
        chk({tag, ".RFA3"}, 32'(RFA3), 32'(a3));
        chk({tag, ".WD3"}, WD3, wd);
        chk({tag, ".PCWrite"}, 32'(PCWrite), 32'(pcw));
    endtask

    task automatic launch(input logic ld, input logic [15:0] lst, input logic [3:0] rn,
                          input logic [31:0] base, input logic up, input logic pre, input logic wb);
        Start = 1'b1; IsLoad = ld; RegList = lst; Rn = rn;
        BaseVal = base; Up = up; Pre = pre; WBack = wb;
        settle();
        chk("launch.Busy", 32'(Busy), 32'd0);
        $display("START ld=%0b list=%h rn=%0d base=%h up=%0b pre=%0b wb=%0b", ld, lst, rn, base, up, pre, wb);
        @(posedge CLK);
        #1;
        Start = 1'b0;
        settle();
    endtask

    initial begin
        RESETn = 1'b0; Start = 1'b0; IsLoad = 1'b0; RegList = 16'd0; Rn = 4'd0;
        BaseVal = 32'd0; Up = 1'b1; Pre = 1'b0; WBack = 1'b0; MemReady = 1'b0; ReadData = 32'd0;
        tick(); tick();
        chk("rst.Busy", 32'(Busy), 32'd0);
        chk("rst.Done", 32'(Done), 32'd0);
        chk_mem("rst", 1'b0, 1'b0, 32'd0);
        chk_rf("rst", 1'b0, 4'd0, 32'd0, 1'b0);
        RESETn = 1'b1;
        tick();

        // STM IA R1,R2,R4 from 0x100 with writeback to R3
        MemReady = 1'b1;
        launch(1'b0, 16'h0016, 4'd3, 32'h100, 1'b1, 1'b0, 1'b1);
        chk_mem("stm.a0", 1'b1, 1'b1, 32'h100);
        chk("stm.a0.RFA1", 32'(RFA1), 32'd1);
        chk("stm.a0.WData", MemWData, 32'hD0000001);
        chk("stm.a0.WE3", 32'(WE3), 32'd0);
        chk("stm.a0.Busy", 32'(Busy), 32'd1);
        $display("STM access addr=%h data=%h", MemAddr, MemWData);
        tick();
        chk_mem("stm.a1", 1'b1, 1'b1, 32'h104);
        chk("stm.a1.WData", MemWData, 32'hD0000002);
        $display("STM access addr=%h data=%h", MemAddr, MemWData);
        tick();
        chk_mem("stm.a2", 1'b1, 1'b1, 32'h108);
        chk("stm.a2.WData", MemWData, 32'hD0000004);
        chk("stm.a2.Done", 32'(Done), 32'd0);
        $display("STM access addr=%h data=%h", MemAddr, MemWData);
        tick();
        chk_mem("stm.wb", 1'b0, 1'b0, 32'h0);
        chk_rf("stm.wb", 1'b1, 4'd3, 32'h10C, 1'b0);
        chk("stm.wb.Done", 32'(Done), 32'd0);
        $display("STM writeback R%0d=%h", RFA3, WD3);
        tick();
        chk("stm.Done", 32'(Done), 32'd1);
        chk("stm.Done.Busy", 32'(Busy), 32'd1);
        chk("stm.Done.WE3", 32'(WE3), 32'd0);
        tick();
        chk("stm.idle.Busy", 32'(Busy), 32'd0);
        chk("stm.idle.Done", 32'(Done), 32'd0);

        // LDM DB R0,R1,R15 from 0x200, no writeback
        launch(1'b1, 16'h8003, 4'd5, 32'h200, 1'b0, 1'b1, 1'b0);
        ReadData = 32'hAAAA0000; settle();
        chk_mem("ldm.a0", 1'b1, 1'b0, 32'h1F4);
        chk_rf("ldm.a0", 1'b1, 4'd0, 32'hAAAA0000, 1'b0);
        $display("LDM access addr=%h R%0d<=%h", MemAddr, RFA3, WD3);
        tick(); ReadData = 32'hAAAA0001; settle();
        chk_mem("ldm.a1", 1'b1, 1'b0, 32'h1F8);
        chk_rf("ldm.a1", 1'b1, 4'd1, 32'hAAAA0001, 1'b0);
        $display("LDM access addr=%h R%0d<=%h", MemAddr, RFA3, WD3);
        tick(); ReadData = 32'h00008000; settle();
        chk_mem("ldm.a2", 1'b1, 1'b0, 32'h1FC);
        chk_rf("ldm.a2", 1'b0, 4'd0, 32'h00008000, 1'b1);
        $display("LDM access addr=%h PC<=%h", MemAddr, WD3);
        tick();
        chk("ldm.Done", 32'(Done), 32'd1);
        chk("ldm.Done.WE3", 32'(WE3), 32'd0);
        tick();

        // LDM IA R1,R2 with Rn=R2, stalled memory; writeback suppressed
        MemReady = 1'b0;
        launch(1'b1, 16'h0006, 4'd2, 32'h300, 1'b1, 1'b0, 1'b1);
        ReadData = 32'h11111111; settle();
        chk_mem("stall.c0", 1'b1, 1'b0, 32'h300);
        chk("stall.c0.WE3", 32'(WE3), 32'd0);
        tick(); MemReady = 1'b1; settle();
        chk_mem("stall.c1", 1'b1, 1'b0, 32'h300);
        chk_rf("stall.c1", 1'b1, 4'd1, 32'h11111111, 1'b0);
        $display("LDM access addr=%h R%0d<=%h", MemAddr, RFA3, WD3);
        tick(); MemReady = 1'b0; ReadData = 32'h22222222; settle();
        chk_mem("stall.c2", 1'b1, 1'b0, 32'h304);
        chk("stall.c2.WE3", 32'(WE3), 32'd0);
        tick();
        chk_mem("stall.c3", 1'b1, 1'b0, 32'h304);
        chk("stall.c3.WE3", 32'(WE3), 32'd0);
        tick(); MemReady = 1'b1; settle();
        chk_rf("stall.c4", 1'b1, 4'd2, 32'h22222222, 1'b0);
        $display("LDM access addr=%h R%0d<=%h", MemAddr, RFA3, WD3);
        tick();
        chk("stall.Done", 32'(Done), 32'd1);
        chk("stall.noWB.WE3", 32'(WE3), 32'd0);
        tick();

        // Empty register list
        launch(1'b0, 16'h0000, 4'd1, 32'h500, 1'b1, 1'b0, 1'b1);
        chk("empty.Busy", 32'(Busy), 32'd1);
        chk("empty.Done", 32'(Done), 32'd1);
        chk("empty.MemReq", 32'(MemReq), 32'd0);
        chk("empty.WE3", 32'(WE3), 32'd0);
        $display("EMPTY done busy=%0b done=%0b", Busy, Done);
        tick();
        chk("empty.idle.Busy", 32'(Busy), 32'd0);

        // Reset during the second access of a 4-register LDM
        launch(1'b1, 16'h000F, 4'd6, 32'h400, 1'b1, 1'b0, 1'b1);
        ReadData = 32'h33333333; settle();
        chk_rf("rstx.a0", 1'b1, 4'd0, 32'h33333333, 1'b0);
        tick();
        chk_mem("rstx.a1", 1'b1, 1'b0, 32'h404);
        RESETn = 1'b0;
        tick();
        RESETn = 1'b1; settle();
        chk("rstx.Busy", 32'(Busy), 32'd0);
        chk("rstx.MemReq", 32'(MemReq), 32'd0);
        chk("rstx.WE3", 32'(WE3), 32'd0);
        $display("RESET mid-transfer busy=%0b memreq=%0b", Busy, MemReq);
        tick();
        chk("rstx.after.WE3", 32'(WE3), 32'd0);
        chk("rstx.after.Busy", 32'(Busy), 32'd0);

        // STM IA wrapping from 0xFFFFFFFC; a second Start while busy is ignored
        launch(1'b0, 16'h0003, 4'd4, 32'hFFFFFFFC, 1'b1, 1'b0, 1'b1);
        Start = 1'b1; RegList = 16'h00F0; BaseVal = 32'h800; IsLoad = 1'b1; settle();
        chk_mem("wrap.a0", 1'b1, 1'b1, 32'hFFFFFFFC);
        chk("wrap.a0.WData", MemWData, 32'hD0000000);
        $display("STM access addr=%h data=%h", MemAddr, MemWData);
        tick();
        Start = 1'b0; settle();
        chk_mem("wrap.a1", 1'b1, 1'b1, 32'h00000000);
        chk("wrap.a1.WData", MemWData, 32'hD0000001);
        $display("STM access addr=%h data=%h", MemAddr, MemWData);
        tick();
        chk_rf("wrap.wb", 1'b1, 4'd4, 32'h00000004, 1'b0);
        $display("STM writeback R%0d=%h", RFA3, WD3);
        tick();
        chk("wrap.Done", 32'(Done), 32'd1);
        tick();
        chk("wrap.idle.Busy", 32'(Busy), 32'd0);
        chk("wrap.idle.MemReq", 32'(MemReq), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
